// File: rtl/count_display_scan_if.sv
// -----------------------------------------------------------------------------
// count_display_scan_if
// Groups the count input, blank control and display outputs of the 2-digit
// seven-segment scanner.
//   Count  : 4-bit counter value, asynchronous to the scanner clock
//   Blank  : 1 = force the display dark
//   Seg    : active-low segments, Seg[0]=a .. Seg[6]=g
//   An     : active-low anode enables, An[0]=units, An[1]=tens
//   Zero   : 1 while the displayed value is 0
// master drives Count/Blank and observes the display; slave is the scanner.
// -----------------------------------------------------------------------------
interface count_display_scan_if;
    logic [3:0] Count;
    logic       Blank;
    logic [6:0] Seg;
    logic [1:0] An;
    logic       Zero;

    modport master (output Count, Blank, input Seg, An, Zero);
    modport slave  (input Count, Blank, output Seg, An, Zero);
endinterface

// File: rtl/count_display_scan.sv
// -----------------------------------------------------------------------------
// count_display_scan
// Shows a 4-bit count (0..15) in decimal on a 2-digit multiplexed common-anode
// seven-segment display. The count is synchronised into the scan clock domain,
// the two digits are time-multiplexed with an all-off guard interval at the
// start of every slot, a leading zero in the tens digit is blanked, and the
// display blinks while the value is zero.
// Ports:
//   clk_50M : scan clock, rising edge
//   Reset   : asynchronous active-low reset
//   bus     : slave side of count_display_scan_if (Count, Blank in;
//             Seg, An, Zero out, all outputs registered)
// -----------------------------------------------------------------------------
module count_display_scan #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int GUARD    = 16,
    parameter int BLINK_HZ = 2
) (
    input  logic                 clk_50M,
    input  logic                 Reset,
    count_display_scan_if.slave  bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;          // cycles per digit slot
    localparam int HB  = CLK_HZ / (2 * BLINK_HZ);   // blink half period
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (HB  > 1) ? $clog2(HB)  : 1;

    typedef enum logic [1:0] {
        GUARD_U = 2'd0,
        UNITS   = 2'd1,
        GUARD_T = 2'd2,
        TENS    = 2'd3
    } state_t;

    // Active-low seven-segment pattern for one decimal digit.
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    logic [3:0]    s1_q, s2_q, held_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_on_q;
    state_t        state_q, state_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          zero_q;

    logic          wrap;
    logic          tens;
    logic [3:0]    units;

    // -------------------------------------------------------------------------
    // Input synchroniser. held only accepts a value that both flops agree on,
    // so a multi-bit change caught mid-transition never reaches the display.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            s1_q   <= 4'd0;
            s2_q   <= 4'd0;
            held_q <= 4'd0;
        end else begin
            s1_q <= bus.Count;
            s2_q <= s1_q;
            if (s2_q == s1_q) begin
                held_q <= s2_q;
            end
        end
    end

    // Decimal split: 0..15 only, so tens is a single bit.
    assign tens  = (held_q >= 4'd10);
    assign units = tens ? (held_q - 4'd10) : held_q;

    // -------------------------------------------------------------------------
    // Slot prescaler: 0..DIV-1, wrap pulse advances to the next slot.
    // -------------------------------------------------------------------------
    assign wrap = (presc_q == PW'(DIV - 1));

    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            presc_q <= '0;
        end else if (wrap) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Blink: parked in the ON phase with a cleared counter while the value is
    // non-zero, so reaching zero always starts with a full ON half period.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (held_q != 4'd0) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BW'(HB - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Scan FSM: state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            state_q <= GUARD_U;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan FSM: next state and the display pattern for the output register.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        an_d    = 2'b11;
        seg_d   = 7'h7F;
        case (state_q)
            GUARD_U: begin
                if (presc_q == PW'(GUARD - 1)) state_d = UNITS;
            end
            UNITS: begin
                if (wrap) state_d = GUARD_T;
                an_d  = 2'b10;
                seg_d = enc(units);
            end
            GUARD_T: begin
                if (presc_q == PW'(GUARD - 1)) state_d = TENS;
            end
            TENS: begin
                if (wrap) state_d = GUARD_U;
                // Leading-zero blanking: the tens digit only lights for 10..15.
                if (tens) begin
                    an_d  = 2'b01;
                    seg_d = enc(4'd1);
                end
            end
            default: state_d = GUARD_U;
        endcase
        // Blank and the blink OFF phase darken the display; scanning continues.
        if (bus.Blank || !blink_on_q) begin
            an_d  = 2'b11;
            seg_d = 7'h7F;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            seg_q  <= 7'h7F;
            an_q   <= 2'b11;
            zero_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            an_q   <= an_d;
            zero_q <= (held_q == 4'd0);
        end
    end

    assign bus.Seg  = seg_q;
    assign bus.An   = an_q;
    assign bus.Zero = zero_q;

endmodule

// File: tb/tb_count_display_scan.sv
// -----------------------------------------------------------------------------
// tb_count_display_scan
// Directed bench for count_display_scan with a 20-cycle scan frame
// (DIV=10, GUARD=2) and a 50-cycle blink half period.
// Outputs are sampled on the falling clock edge. cyc counts rising edges since
// reset release; the display in cycle cyc reflects the scan state of cycle
// cyc-1, i.e. frame position p = (cyc-1) mod 20:
//   p 0..1 guard, p 2..9 units, p 10..11 guard, p 12..19 tens.
// -----------------------------------------------------------------------------
module tb_count_display_scan;

    localparam int CLK_HZ   = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int GUARD    = 2;
    localparam int BLINK_HZ = 10;
    localparam int FRAME    = 20;

    logic clk_50M = 1'b0;
    logic Reset   = 1'b0;
    int   cyc;
    int   n_cmp = 0;
    int   n_err = 0;

    count_display_scan_if bus ();

    count_display_scan #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .GUARD   (GUARD),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk_50M(clk_50M),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    // Expected display for the current cycle from its frame position.
    task automatic check_cycle(input string tag, input logic [6:0] useg,
                               input bit tlit, input bit on);
        int         p;
        logic [1:0] ea;
        logic [6:0] es;
        p  = (cyc - 1) % FRAME;
        ea = 2'b11;
        es = 7'h7F;
        if (on) begin
            if (p >= 2 && p <= 9) begin
                ea = 2'b10;
                es = useg;
            end else if (p >= 12 && tlit) begin
                ea = 2'b01;
                es = 7'h79;
            end
        end
        check({tag, "_an"},  {6'd0, bus.An},  {6'd0, ea});
        check({tag, "_seg"}, {1'b0, bus.Seg}, {1'b0, es});
    endtask

    // Step until the sample just taken is the last position of a frame.
    task automatic align();
        for (int i = 0; i < FRAME && ((cyc - 1) % FRAME) != FRAME - 1; i++) step(1);
    endtask

    task automatic check_frame(input string tag, input logic [6:0] useg, input bit tlit);
        for (int i = 0; i < FRAME; i++) begin
            step(1);
            check_cycle(tag, useg, tlit, 1'b1);
        end
    endtask

    // After a glitched change: no tens digit, no enc(5) in the units slot.
    task automatic check_no_glitch(input string tag);
        logic ok;
        for (int i = 0; i < 8; i++) begin
            step(1);
            ok = (bus.An != 2'b01) && !(bus.An == 2'b10 && bus.Seg == 7'h12)
                 && (bus.An != 2'b00);
            check(tag, {7'd0, ok}, 8'd1);
        end
    endtask

    initial begin
        bus.Count = 4'd7;
        bus.Blank = 1'b0;

        // 1: reset values, then count 7 with tens blanked
        step(2);
        check("rst_an",   {6'd0, bus.An},  8'h03);
        check("rst_seg",  {1'b0, bus.Seg}, 8'h7F);
        check("rst_zero", {7'd0, bus.Zero}, 8'h00);
        Reset = 1'b1;
        step(3);
        check("t1_zero_c3", {7'd0, bus.Zero}, 8'h01);
        step(1);
        check("t1_zero_c4", {7'd0, bus.Zero}, 8'h00);
        align();
        check_frame("t1_7", 7'h78, 1'b0);

        // 2: count 13 lights both digits
        bus.Count = 4'd13;
        step(5);
        align();
        check_frame("t2_13", 7'h30, 1'b1);

        // 3: 1 -> 0 blinks; 5 mid-OFF restores the display
        bus.Count = 4'd1;
        step(5);
        check("t3_zero_1", {7'd0, bus.Zero}, 8'h00);
        bus.Count = 4'd0;
        step(3);
        check("t3_zero_c3", {7'd0, bus.Zero}, 8'h00);
        step(1);
        check("t3_zero_c4", {7'd0, bus.Zero}, 8'h01);
        for (int i = 0; i < 50; i++) begin
            if (i > 0) step(1);
            check_cycle("t3_on", 7'h40, 1'b0, 1'b1);
        end
        for (int i = 0; i < 17; i++) begin
            step(1);
            check_cycle("t3_off", 7'h40, 1'b0, 1'b0);
        end
        bus.Count = 4'd5;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_cycle("t3_restore_wait", 7'h12, 1'b0, 1'b0);
            if (i == 2) check("t3_zero_hold", {7'd0, bus.Zero}, 8'h01);
            if (i == 3) check("t3_zero_clr",  {7'd0, bus.Zero}, 8'h00);
        end
        check_frame("t3_5", 7'h12, 1'b0);

        // 4: 9 <-> 6 with a one-cycle 15 in between
        bus.Count = 4'd9;
        step(5);
        align();
        check_frame("t4_9", 7'h10, 1'b0);
        bus.Count = 4'd15;
        step(1);
        bus.Count = 4'd6;
        check_no_glitch("t4_glitch_a");
        align();
        check_frame("t4_6", 7'h02, 1'b0);
        bus.Count = 4'd15;
        step(1);
        bus.Count = 4'd9;
        check_no_glitch("t4_glitch_b");
        align();
        check_frame("t4_9b", 7'h10, 1'b0);

        // 5: Blank for 30 cycles starting inside the units slot
        align();
        step(4);
        check_cycle("t5_pre", 7'h10, 1'b0, 1'b1);
        bus.Blank = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            check("t5_blank_an",  {6'd0, bus.An},  8'h03);
            check("t5_blank_seg", {1'b0, bus.Seg}, 8'h7F);
        end
        bus.Blank = 1'b0;
        check_frame("t5_resume", 7'h10, 1'b0);

        // 6: asynchronous reset in the middle of the tens slot
        bus.Count = 4'd13;
        step(5);
        align();
        step(14);
        check_cycle("t6_tens", 7'h30, 1'b1, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("t6_async_an",   {6'd0, bus.An},  8'h03);
        check("t6_async_seg",  {1'b0, bus.Seg}, 8'h7F);
        check("t6_async_zero", {7'd0, bus.Zero}, 8'h00);
        step(2);
        Reset = 1'b1;
        for (int i = 1; i <= FRAME; i++) begin
            step(1);
            check_cycle("t6_restart", (i == 3) ? 7'h40 : 7'h30, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
